// File: rtl/exa_crosb_output_vc_allocator.sv
// Output-VC allocator for one crossbar output port: round-robin over header
// requests, output VC either mirrors the input VC or is any free VC of its class.
module exa_crosb_output_vc_allocator #(
  parameter int prio_num   = 2,
  parameter int vc_num     = 2,
  parameter int NUM_IN     = 4,
  parameter int ALLOC_MODE = 1,
  localparam int NVC  = prio_num * vc_num,
  localparam int VCW  = (NVC > 1) ? $clog2(NVC) : 1,
  localparam int IDXW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] i_req,
  input  logic [VCW-1:0]    i_req_vc [NUM_IN-1:0],
  output logic [NUM_IN-1:0] o_gnt,
  output logic [VCW-1:0]    o_gnt_vc,
  input  logic [NVC-1:0]    i_release,
  output logic [NVC-1:0]    o_vc_busy,
  output logic [IDXW-1:0]   o_vc_owner [NVC-1:0]
);

  logic [NUM_IN-1:0] elig;
  logic [VCW-1:0]    tgt [NUM_IN-1:0];
  logic [IDXW-1:0]   rr_ptr;
  logic              gnt_any;
  logic [IDXW-1:0]   gnt_idx;
  logic [NUM_IN-1:0] gnt_nxt;
  logic [VCW-1:0]    gnt_vc_nxt;

  // Target selection looks only at the registered busy vector, so a VC being
  // released this cycle is not handed out until the next one.
  always_comb begin
    int  base;
    int  v;
    logic hit;
    base = 0;
    v    = 0;
    hit  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      hit    = 1'b0;
      tgt[i] = '0;
      if (ALLOC_MODE == 0) begin
        if (int'(i_req_vc[i]) < NVC && !o_vc_busy[i_req_vc[i]]) begin
          hit    = 1'b1;
          tgt[i] = i_req_vc[i];
        end
      end else begin
        base = (int'(i_req_vc[i]) / vc_num) * vc_num;
        for (int k = vc_num - 1; k >= 0; k--) begin
          v = base + k;
          if (int'(i_req_vc[i]) < NVC && v < NVC && !o_vc_busy[v]) begin
            hit    = 1'b1;
            tgt[i] = VCW'(v);
          end
        end
      end
      elig[i] = hit & i_req[i] & ~o_gnt[i];
    end
  end

  // Scan downward from pointer+NUM_IN-1 so the input closest to the pointer wins.
  always_comb begin
    int p;
    p       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      p = (int'(rr_ptr) + k) % NUM_IN;
      if (elig[p]) begin
        gnt_any = 1'b1;
        gnt_idx = IDXW'(p);
      end
    end
    gnt_nxt    = gnt_any ? (NUM_IN'(1) << gnt_idx) : '0;
    gnt_vc_nxt = tgt[gnt_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_gnt     <= '0;
      o_gnt_vc  <= '0;
      o_vc_busy <= '0;
      rr_ptr    <= '0;
      for (int v = 0; v < NVC; v++) o_vc_owner[v] <= '0;
    end else begin
      o_gnt    <= gnt_nxt;
      o_gnt_vc <= gnt_any ? gnt_vc_nxt : '0;
      if (gnt_any) rr_ptr <= IDXW'((int'(gnt_idx) + 1) % NUM_IN);
      for (int v = 0; v < NVC; v++) begin
        if (i_release[v]) begin
          o_vc_busy[v]  <= 1'b0;
          o_vc_owner[v] <= '0;
        end
      end
      // A granted VC was free pre-release, so any release bit on it is a no-op.
      if (gnt_any) begin
        o_vc_busy[gnt_vc_nxt]  <= 1'b1;
        o_vc_owner[gnt_vc_nxt] <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_exa_crosb_output_vc_allocator.sv
// Directed bench for the output-VC allocator: one instance per allocation mode,
// expected grants queued when stimulus is driven and compared one cycle later.
module tb_exa_crosb_output_vc_allocator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req1 = '0, req0 = '0;
  logic [3:0] rel1 = '0, rel0 = '0;
  logic [1:0] rvc1 [3:0];
  logic [1:0] rvc0 [3:0];
  logic [3:0] gnt1, gnt0, busy1, busy0;
  logic [1:0] gvc1, gvc0;
  logic [1:0] own1 [3:0];
  logic [1:0] own0 [3:0];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         sel;
    logic [3:0] g;
    logic [1:0] v;
    string      tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  exa_crosb_output_vc_allocator #(
    .prio_num(2), .vc_num(2), .NUM_IN(4), .ALLOC_MODE(1)
  ) dut1 (
    .clk(clk), .reset(reset), .i_req(req1), .i_req_vc(rvc1),
    .o_gnt(gnt1), .o_gnt_vc(gvc1), .i_release(rel1),
    .o_vc_busy(busy1), .o_vc_owner(own1)
  );

  exa_crosb_output_vc_allocator #(
    .prio_num(2), .vc_num(2), .NUM_IN(4), .ALLOC_MODE(0)
  ) dut0 (
    .clk(clk), .reset(reset), .i_req(req0), .i_req_vc(rvc0),
    .o_gnt(gnt0), .o_gnt_vc(gvc0), .i_release(rel0),
    .o_vc_busy(busy0), .o_vc_owner(own0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int sel, input logic [3:0] g, input logic [1:0] v, input string tag);
    exp_t e;
    sb.push_back('{sel, g, v, tag});
    tick();
    e = sb.pop_front();
    if (e.sel == 1) begin
      chk({e.tag, "_gnt"}, {4'b0, gnt1}, {4'b0, e.g});
      if (e.g != 4'b0) chk({e.tag, "_vc"}, {6'b0, gvc1}, {6'b0, e.v});
    end else begin
      chk({e.tag, "_gnt"}, {4'b0, gnt0}, {4'b0, e.g});
      if (e.g != 4'b0) chk({e.tag, "_vc"}, {6'b0, gvc0}, {6'b0, e.v});
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rvc1[i] = 2'd0;
      rvc0[i] = 2'd0;
    end

    // reset held with all inputs requesting
    req1 = 4'hF;
    req0 = 4'hF;
    tick();
    tick();
    chk("rst_gnt1", {4'b0, gnt1}, 8'h0);
    chk("rst_gnt0", {4'b0, gnt0}, 8'h0);
    chk("rst_busy1", {4'b0, busy1}, 8'h0);
    chk("rst_gvc1", {6'b0, gvc1}, 8'h0);
    for (int v = 0; v < 4; v++) chk("rst_own1", {6'b0, own1[v]}, 8'h0);
    req1 = '0;
    req0 = '0;
    reset = 1'b0;
    tick();
    chk("idle_busy0", {4'b0, busy0}, 8'h0);

    // single request in mode 1, then release
    req1 = 4'b0001;
    rvc1[0] = 2'd2;
    cyc(1, 4'b0001, 2'd2, "a_g");
    req1 = '0;
    chk("a_busy", {4'b0, busy1}, 8'h04);
    chk("a_own2", {6'b0, own1[2]}, 8'h0);
    rel1 = 4'b0100;
    cyc(1, 4'b0000, 2'd0, "a_rel");
    rel1 = '0;
    chk("a_busy_clr", {4'b0, busy1}, 8'h0);

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // all four inputs contend for class 0
    rvc1[0] = 2'd0; rvc1[1] = 2'd1; rvc1[2] = 2'd0; rvc1[3] = 2'd1;
    req1 = 4'hF;
    cyc(1, 4'b0001, 2'd0, "b_g0");
    req1[0] = 1'b0;
    cyc(1, 4'b0010, 2'd1, "b_g1");
    req1[1] = 1'b0;
    cyc(1, 4'b0000, 2'd0, "b_stall1");
    cyc(1, 4'b0000, 2'd0, "b_stall2");
    chk("b_busy", {4'b0, busy1}, 8'h03);
    rel1 = 4'b0001;
    cyc(1, 4'b0000, 2'd0, "b_rel0");
    rel1 = '0;
    cyc(1, 4'b0100, 2'd0, "b_g2");
    req1[2] = 1'b0;
    rel1 = 4'b0010;
    req1[0] = 1'b1;
    cyc(1, 4'b0000, 2'd0, "b_rel1");
    rel1 = '0;
    cyc(1, 4'b1000, 2'd1, "b_ptr3");
    req1[3] = 1'b0;
    chk("b_own1", {6'b0, own1[1]}, 8'h3);
    chk("b_own0", {6'b0, own1[0]}, 8'h2);
    rel1 = 4'b0011;
    cyc(1, 4'b0000, 2'd0, "b_relboth");
    rel1 = '0;
    cyc(1, 4'b0001, 2'd0, "b_g0b");
    req1[0] = 1'b0;

    // release coinciding with a new request; release of a free VC
    req1[1] = 1'b1;
    cyc(1, 4'b0010, 2'd1, "c_g1");
    req1[1] = 1'b0;
    chk("c_own1a", {6'b0, own1[1]}, 8'h1);
    rel1 = 4'b0010;
    req1[2] = 1'b1;
    cyc(1, 4'b0000, 2'd0, "c_same");
    rel1 = '0;
    cyc(1, 4'b0100, 2'd1, "c_g1later");
    req1[2] = 1'b0;
    chk("c_own1b", {6'b0, own1[1]}, 8'h2);
    rel1 = 4'b1000;
    cyc(1, 4'b0000, 2'd0, "c_relfree");
    rel1 = '0;
    chk("c_busy", {4'b0, busy1}, 8'h03);
    chk("c_own1c", {6'b0, own1[1]}, 8'h2);

    // mode 0: two inputs want VC3
    rvc0[1] = 2'd3;
    rvc0[3] = 2'd3;
    req0 = 4'b1010;
    cyc(0, 4'b0010, 2'd3, "d_g1");
    req0[1] = 1'b0;
    cyc(0, 4'b0000, 2'd0, "d_wait1");
    cyc(0, 4'b0000, 2'd0, "d_wait2");
    rel0 = 4'b1000;
    cyc(0, 4'b0000, 2'd0, "d_rel");
    rel0 = '0;
    cyc(0, 4'b1000, 2'd3, "d_g3");
    req0[3] = 1'b0;
    chk("d_own3", {6'b0, own0[3]}, 8'h3);
    chk("d_busy", {4'b0, busy0}, 8'h08);

    // asynchronous reset with VCs 0 and 3 busy and a grant pending
    req0[0] = 1'b1;
    rvc0[0] = 2'd0;
    cyc(0, 4'b0001, 2'd0, "e_g0");
    req0[0] = 1'b0;
    req0[2] = 1'b1;
    rvc0[2] = 2'd2;
    cyc(0, 4'b0100, 2'd2, "e_pend");
    chk("e_busy_pre", {4'b0, busy0}, 8'h0D);
    #1 reset = 1'b1;
    #1;
    chk("e_rst_gnt", {4'b0, gnt0}, 8'h0);
    chk("e_rst_busy", {4'b0, busy0}, 8'h0);
    chk("e_rst_own3", {6'b0, own0[3]}, 8'h0);
    chk("e_rst_own2", {6'b0, own0[2]}, 8'h0);
    req0 = '0;
    tick();
    reset = 1'b0;
    rvc0[0] = 2'd0;
    rvc0[3] = 2'd3;
    req0 = 4'b1001;
    cyc(0, 4'b0001, 2'd0, "e_restart");
    req0 = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
